// File: rtl/lfsr_16_checker.sv
// lfsr_16_checker: receive-side sequence checker for the 16-bit LFSR pattern
// generator. It self-synchronises to an incoming word stream (one generator
// step per valid beat). Once locked it flywheels its own prediction, and it
// flags and counts every received word that deviates from that prediction.
module lfsr_16_checker #(
   parameter int LOCK_COUNT = 4,  // consecutive correct predictions to lock (1..15)
   parameter int LOSS_COUNT = 8   // consecutive mismatches to drop lock (1..15)
) (
   input  logic        clk_in,
   input  logic        rst_n_in,
   input  logic        clr_in,
   input  logic [15:0] data_in,
   input  logic        valid_in,
   output logic        locked_out,
   output logic        err_out,
   output logic [31:0] err_count_out,
   output logic [31:0] beat_count_out
);

   localparam logic [3:0] LOCK_THR = 4'(LOCK_COUNT);
   localparam logic [3:0] LOSS_THR = 4'(LOSS_COUNT);

   typedef enum logic {
      SEARCH = 1'b0,
      LOCKED = 1'b1
   } state_t;

   state_t      state, state_nxt;
   logic [15:0] pred, pred_nxt;
   logic        have_pred, have_pred_nxt;
   logic [3:0]  match_cnt, match_cnt_nxt;
   logic [3:0]  miss_cnt, miss_cnt_nxt;
   logic        err_nxt;
   logic [31:0] err_count_nxt, beat_count_nxt;

   logic        data_zero;
   logic        pred_hit;
   logic [3:0]  match_inc;
   logic [3:0]  miss_inc;
   logic [15:0] next_of_data;
   logic [15:0] next_of_pred;

   // Generator recurrence: a shift with feedback taps from bit 15 into bits 0, 2 and 15.
   function automatic logic [15:0] lfsr_next(input logic [15:0] q);
      logic [15:0] n;
      n[0]    = q[15];
      n[1]    = q[0];
      n[2]    = q[15] ^ q[1];
      n[14:3] = q[13:2];
      n[15]   = q[15] ^ q[14];
      return n;
   endfunction

   // Saturating 32-bit increment; counters hold at all-ones.
   function automatic logic [31:0] sat_inc(input logic [31:0] c);
      return (c == '1) ? c : c + 32'd1;
   endfunction

   assign data_zero    = (data_in == '0);
   assign pred_hit     = (data_in == pred);
   assign match_inc    = match_cnt + 4'd1;
   assign miss_inc     = miss_cnt + 4'd1;
   assign next_of_data = lfsr_next(data_in);
   assign next_of_pred = lfsr_next(pred);

   // Lock status comes straight from the state register.
   assign locked_out = (state == LOCKED);

   // State and counter registers; async active-low reset to SEARCH with zeroed outputs.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state          <= SEARCH;
         pred           <= '0;
         have_pred      <= 1'b0;
         match_cnt      <= '0;
         miss_cnt       <= '0;
         err_out        <= 1'b0;
         err_count_out  <= '0;
         beat_count_out <= '0;
      end else begin
         state          <= state_nxt;
         pred           <= pred_nxt;
         have_pred      <= have_pred_nxt;
         match_cnt      <= match_cnt_nxt;
         miss_cnt       <= miss_cnt_nxt;
         err_out        <= err_nxt;
         err_count_out  <= err_count_nxt;
         beat_count_out <= beat_count_nxt;
      end
   end

   // Next-state: search/seed/lock while SEARCH; flywheel and error accounting while LOCKED.
   always_comb begin
      state_nxt      = state;
      pred_nxt       = pred;
      have_pred_nxt  = have_pred;
      match_cnt_nxt  = match_cnt;
      miss_cnt_nxt   = miss_cnt;
      err_nxt        = 1'b0;
      err_count_nxt  = err_count_out;
      beat_count_nxt = beat_count_out;

      if (valid_in) begin
         case (state)
            SEARCH: begin
               if (data_zero) begin
                  // All-zero is the recurrence's fixed point and is never a seed.
                  have_pred_nxt = 1'b0;
                  match_cnt_nxt = '0;
               end else if (!have_pred) begin
                  pred_nxt      = next_of_data;
                  have_pred_nxt = 1'b1;
                  match_cnt_nxt = '0;
               end else if (pred_hit) begin
                  pred_nxt      = next_of_data;
                  match_cnt_nxt = match_inc;
                  if (match_inc == LOCK_THR) begin
                     state_nxt    = LOCKED;
                     miss_cnt_nxt = '0;
                  end
               end else begin
                  // Nonzero here, so the received word reseeds the prediction.
                  pred_nxt      = next_of_data;
                  match_cnt_nxt = '0;
               end
            end
            LOCKED: begin
               beat_count_nxt = sat_inc(beat_count_out);
               pred_nxt       = next_of_pred;
               if (pred_hit) begin
                  miss_cnt_nxt = '0;
               end else begin
                  err_nxt       = 1'b1;
                  err_count_nxt = sat_inc(err_count_out);
                  miss_cnt_nxt  = miss_inc;
                  if (miss_inc == LOSS_THR) begin
                     state_nxt     = SEARCH;
                     have_pred_nxt = 1'b0;
                     match_cnt_nxt = '0;
                  end
               end
            end
            default: begin
               state_nxt = SEARCH;
            end
         endcase
      end

      // Clear overrides any increment on the same cycle; err_out is unaffected.
      if (clr_in) begin
         err_count_nxt  = '0;
         beat_count_nxt = '0;
      end
   end

endmodule

// File: tb/tb_lfsr_16_checker.sv
// Directed testbench for lfsr_16_checker: a reference model predicts the
// outputs of every driven cycle into a scoreboard queue, and these are popped
// and compared after the clock edge. Extra spot checks use fixed constants.
module tb_lfsr_16_checker;

   localparam int LOCK = 4;
   localparam int LOSS = 8;

   logic        clk_in = 1'b0;
   logic        rst_n_in;
   logic        clr_in;
   logic [15:0] data_in;
   logic        valid_in;
   logic        locked_out;
   logic        err_out;
   logic [31:0] err_count_out;
   logic [31:0] beat_count_out;

   lfsr_16_checker #(.LOCK_COUNT(LOCK), .LOSS_COUNT(LOSS)) dut (
      .clk_in         (clk_in),
      .rst_n_in       (rst_n_in),
      .clr_in         (clr_in),
      .data_in        (data_in),
      .valid_in       (valid_in),
      .locked_out     (locked_out),
      .err_out        (err_out),
      .err_count_out  (err_count_out),
      .beat_count_out (beat_count_out)
   );

   always #5 clk_in = ~clk_in;

   typedef struct packed {
      logic        locked;
      logic        err;
      logic [31:0] ec;
      logic [31:0] bc;
   } exp_t;

   exp_t sbq[$];

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state
   bit          m_locked;
   logic [15:0] m_pred;
   bit          m_have;
   int          m_match;
   int          m_miss;
   bit          m_err;
   logic [31:0] m_ec;
   logic [31:0] m_bc;

   function automatic logic [15:0] nxt(input logic [15:0] q);
      return {q[14:0], 1'b0} ^ (q[15] ? 16'h8005 : 16'h0000);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_locked = 0; m_pred = '0; m_have = 0; m_match = 0; m_miss = 0;
      m_err = 0; m_ec = '0; m_bc = '0;
   endtask

   task automatic model_beat(input bit v, input logic [15:0] d, input bit c);
      m_err = 0;
      if (v) begin
         if (!m_locked) begin
            if (d == 16'h0000) begin
               m_have = 0; m_match = 0;
            end else if (!m_have) begin
               m_pred = nxt(d); m_have = 1; m_match = 0;
            end else if (d == m_pred) begin
               m_match++; m_pred = nxt(d);
               if (m_match == LOCK) begin m_locked = 1; m_miss = 0; end
            end else begin
               m_match = 0; m_pred = nxt(d);
            end
         end else begin
            if (m_bc != 32'hFFFF_FFFF) m_bc++;
            if (d != m_pred) begin
               m_err = 1;
               if (m_ec != 32'hFFFF_FFFF) m_ec++;
               m_miss++;
               if (m_miss == LOSS) begin m_locked = 0; m_have = 0; m_match = 0; end
            end else begin
               m_miss = 0;
            end
            m_pred = nxt(m_pred);
         end
      end
      if (c) begin m_ec = '0; m_bc = '0; end
   endtask

   // One clock: drive inputs, predict, then compare after the edge.
   task automatic step(input bit v, input logic [15:0] d, input bit c);
      exp_t e;
      valid_in = v; data_in = d; clr_in = c;
      model_beat(v, d, c);
      e.locked = m_locked; e.err = m_err; e.ec = m_ec; e.bc = m_bc;
      sbq.push_back(e);
      @(posedge clk_in);
      #1;
      if (sbq.size() == 0) begin
         chk("sb_empty", 32'd1, 32'd0);
      end else begin
         e = sbq.pop_front();
         chk("locked", 32'(locked_out), 32'(e.locked));
         chk("err", 32'(err_out), 32'(e.err));
         chk("err_count", err_count_out, e.ec);
         chk("beat_count", beat_count_out, e.bc);
      end
   endtask

   // Async reset for one cycle, checking outputs clear before any clock edge.
   task automatic do_reset();
      valid_in = 0; clr_in = 0;
      rst_n_in = 0;
      #1;
      chk("rst_locked", 32'(locked_out), 32'd0);
      chk("rst_err", 32'(err_out), 32'd0);
      chk("rst_err_count", err_count_out, 32'd0);
      chk("rst_beat_count", beat_count_out, 32'd0);
      model_reset();
      sbq.delete();
      @(posedge clk_in);
      #1;
      rst_n_in = 1;
   endtask

   task automatic lock_in(input logic [15:0] seed, input bit gaps, output logic [15:0] nextw);
      logic [15:0] g;
      g = seed;
      for (int i = 0; i < 5; i++) begin
         step(1, g, 0);
         if (i == 3) chk("pre_lock", 32'(locked_out), 32'd0);
         g = nxt(g);
         if (gaps) step(0, 16'($urandom), 0);
      end
      chk("lock", 32'(locked_out), 32'd1);
      chk("lock_err_count", err_count_out, 32'd0);
      nextw = g;
   endtask

   initial begin
      logic [15:0] g;
      logic        saw_err;
      rst_n_in = 0; clr_in = 0; valid_in = 0; data_in = '0;
      model_reset();
      @(posedge clk_in);
      #1;

      // Lock-in and tap path
      do_reset();
      lock_in(16'h04BC, 0, g);
      chk("seq_word", 32'(g), 32'h0000_9780);
      step(1, 16'h9780, 0);
      step(1, 16'hAF05, 0);
      chk("tap_beat_count", beat_count_out, 32'd2);
      chk("tap_err_count", err_count_out, 32'd0);

      // Single error, then correct continuation
      do_reset();
      lock_in(16'h04BC, 0, g);
      step(1, 16'h9780, 0);
      step(1, 16'hAF04, 0);
      chk("single_err_pulse", 32'(err_out), 32'd1);
      g = nxt(16'hAF05);
      saw_err = 0;
      for (int i = 0; i < 6; i++) begin
         step(1, g, 0);
         if (err_out !== 1'b0) saw_err = 1;
         g = nxt(g);
      end
      chk("single_no_more_err", 32'(saw_err), 32'd0);
      chk("single_err_count", err_count_out, 32'd1);
      chk("single_locked", 32'(locked_out), 32'd1);

      // Loss of lock on zeros; zeros never relock
      do_reset();
      lock_in(16'h04BC, 0, g);
      for (int i = 0; i < LOSS; i++) begin
         step(1, 16'h0000, 0);
         if (i == LOSS - 2) chk("loss_still_locked", 32'(locked_out), 32'd1);
      end
      chk("loss_err_count", err_count_out, 32'd8);
      chk("loss_unlocked", 32'(locked_out), 32'd0);
      for (int i = 0; i < 6; i++) step(1, 16'h0000, 0);
      chk("zero_no_relock", 32'(locked_out), 32'd0);
      chk("zero_err_hold", err_count_out, 32'd8);

      // Gapped lock-in, then clear (idle and with a mismatch beat)
      do_reset();
      lock_in(16'h04BC, 1, g);
      step(1, g, 0);
      step(1, 16'h1234, 0);
      chk("pre_clr_err_count", err_count_out, 32'd1);
      step(0, 16'h5555, 1);
      chk("clr_err_count", err_count_out, 32'd0);
      chk("clr_beat_count", beat_count_out, 32'd0);
      chk("clr_locked", 32'(locked_out), 32'd1);
      step(1, 16'hDEAD, 1);
      chk("clr_mis_err", 32'(err_out), 32'd1);
      chk("clr_mis_count", err_count_out, 32'd0);
      step(0, 16'h0000, 0);
      chk("idle_err_low", 32'(err_out), 32'd0);

      // Reset mid-operation, then fresh relock
      do_reset();
      lock_in(16'h04BC, 0, g);
      for (int i = 0; i < 3; i++) step(1, 16'h0000, 0);
      chk("mid_err_count", err_count_out, 32'd3);
      do_reset();
      lock_in(16'h4BC0, 0, g);
      step(1, g, 0);
      chk("relock_beat", beat_count_out, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
